// File: rtl/adder_seq_pkg.sv
// ----------------------------------------------------------------------------
// adder_seq_pkg
// Shared types and width helpers for the adder share sequencer.
//   state_e   : sequencer state (IDLE, RUN, DONE)
//   BYTE_W    : width of one slice processed by the shared adder
//   idx_width : bits needed to index the byte slices of an operand
// ----------------------------------------------------------------------------
package adder_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte-index width; kept at least one bit so the index register always exists.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage : adder_seq_pkg

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter with its own priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> requester 0)
//   req_i[1:0] : request per requester
//   en_i       : arbitration enabled (grants forced to zero when low)
//   grant_o    : one-hot or zero grant; a grant is taken as an accept
// When both request, the pointer side wins. After any grant the pointer
// moves to the requester that did not win.
// ----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    grant_o = 2'b00;
    ptr_d   = ptr_q;
    if (en_i) begin
      unique case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end
    // Winner 0 hands priority to 1 and vice versa.
    if (|grant_o) begin
      ptr_d = grant_o[0];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arbiter2

// File: rtl/adder_share_sequencer.sv
// ----------------------------------------------------------------------------
// adder_share_sequencer
// Shares one external combinational 8-bit adder between two requesters and
// runs multi-byte add/sub through it LSB byte first, chaining the carry.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester request handshake (2 bits each)
//   req_a0/b0, req_a1/b1  : WIDTH-bit operands of requester 0 / 1
//   req_cin, req_sub      : per-requester carry-in and subtract select
//   add_x/add_y/add_cin   : byte operands and carry to the shared adder
//   add_s/add_cout        : sum byte and carry back from the shared adder
//   rsp_valid/rsp_ready   : response handshake, valid held until accepted
//   rsp_id/sum/cout/ovf   : requester index, result, carry-out, signed overflow
//   busy                  : sequencer not idle
// ----------------------------------------------------------------------------
module adder_share_sequencer
  import adder_seq_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int WIDTH  = BYTE_W * NBYTES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [WIDTH-1:0]   req_a0,
  input  logic [WIDTH-1:0]   req_b0,
  input  logic [WIDTH-1:0]   req_a1,
  input  logic [WIDTH-1:0]   req_b1,
  input  logic [1:0]         req_cin,
  input  logic [1:0]         req_sub,
  output logic [BYTE_W-1:0]  add_x,
  output logic [BYTE_W-1:0]  add_y,
  output logic               add_cin,
  input  logic [BYTE_W-1:0]  add_s,
  input  logic               add_cout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_sum,
  output logic               rsp_cout,
  output logic               rsp_ovf,
  output logic               busy
);

  localparam int                IDX_W    = idx_width(NBYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [WIDTH-1:0]   a_q,     a_d;
  logic [WIDTH-1:0]   b_q,     b_d;     // already inverted for subtract
  logic [WIDTH-1:0]   sum_q,   sum_d;
  logic               carry_q, carry_d;
  logic               id_q,    id_d;

  logic [1:0]         grant;
  logic               accept;
  logic               sel_id;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_cin;
  logic               sel_sub;

  // Arbitration only while idle; gating with rst_n keeps req_ready at zero
  // for the whole time reset is held, even with requests pending.
  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req_valid),
    .en_i    ((state_q == IDLE) && rst_n),
    .grant_o (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign sel_id    = grant[1];
  assign sel_a     = sel_id ? req_a1 : req_a0;
  assign sel_b     = sel_id ? req_b1 : req_b0;
  assign sel_cin   = req_cin[sel_id];
  assign sel_sub   = req_sub[sel_id];
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    id_d      = id_q;
    add_x     = '0;
    add_y     = '0;
    add_cin   = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    rsp_sum   = '0;
    rsp_cout  = 1'b0;
    rsp_ovf   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Subtract is A + ~B + 1; the requester's carry-in is ignored.
          a_d     = sel_a;
          b_d     = sel_b ^ {WIDTH{sel_sub}};
          carry_d = sel_sub | sel_cin;
          id_d    = sel_id;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        add_x   = a_q[BYTE_W*idx_q +: BYTE_W];
        add_y   = b_q[BYTE_W*idx_q +: BYTE_W];
        add_cin = carry_q;
        sum_d[BYTE_W*idx_q +: BYTE_W] = add_s;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end

      DONE: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_sum   = sum_q;
        rsp_cout  = carry_q;
        // Carry into the MSB is a^b^s at that bit; overflow is it xor carry-out.
        rsp_ovf   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_q[WIDTH-1] ^ carry_q;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
    end
  end

endmodule : adder_share_sequencer
